// File: rtl/text_pkg.sv
// Shared types and constants for the text overlay sequencer.
package text_pkg;

  localparam int         CHAR_W      = 8;
  localparam int         CHAR_H      = 8;
  localparam logic [7:0] ASCII_SPACE = 8'd32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PEND
  } wr_state_t;

endpackage

// File: rtl/text_buf_2bank.sv
// Double-buffered character store: the writer fills the shadow bank while the
// scan path reads the active bank; a swap exchanges their roles.
module text_buf_2bank
  import text_pkg::*;
#(
  parameter int N_CHARS = 32,
  parameter int AW      = $clog2(N_CHARS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic              swap,
  input  logic [AW-1:0]     rd_addr,
  output logic [CHAR_W-1:0] rd_data
);

  logic [CHAR_W-1:0] bank0 [N_CHARS];
  logic [CHAR_W-1:0] bank1 [N_CHARS];
  logic              bank_sel;

  // Bank select: 0 means bank0 is displayed and bank1 is the shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_sel <= 1'b0;
    end else if (swap) begin
      bank_sel <= ~bank_sel;
    end
  end

  // Writes always land in whichever bank is not being displayed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CHARS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_en) begin
      if (bank_sel) begin
        bank0[wr_addr] <= wr_data;
      end else begin
        bank1[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_data = bank_sel ? bank1[rd_addr] : bank0[rd_addr];

endmodule

// File: rtl/text_overlay_ctrl.sv
// Character-overlay sequencer: accepts a text line over valid/ready, commits it
// at a frame boundary, and turns scan coordinates into registered glyph requests.
module text_overlay_ctrl
  import text_pkg::*;
#(
  parameter int N_CHARS      = 32,
  parameter int TEXT_X0      = 0,
  parameter int TEXT_Y0      = 16,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic       wr_last,
  input  logic       clear,
  input  logic       frame_start,
  input  logic       blink_en,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [7:0] char_code,
  output logic [9:0] char_x,
  output logic [9:0] char_y,
  output logic       char_en,
  output logic       busy
);

  localparam int AW    = $clog2(N_CHARS);
  localparam int LW    = AW + 1;
  localparam int FCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SHIFT = $clog2(CHAR_W);
  localparam int SW    = 10 - SHIFT;

  localparam logic signed [11:0] X0_S   = 12'(TEXT_X0);
  localparam logic signed [11:0] Y0_S   = 12'(TEXT_Y0);
  localparam logic signed [11:0] Y1_S   = 12'(TEXT_Y0 + CHAR_H);
  localparam logic [AW-1:0]      PTR_END = AW'(N_CHARS - 1);
  localparam logic [FCW-1:0]     FC_END  = FCW'(BLINK_FRAMES - 1);

  wr_state_t         state, state_nxt;
  logic [AW-1:0]     wr_ptr;
  logic [LW-1:0]     shadow_len;
  logic [LW-1:0]     active_len;
  logic [FCW-1:0]    frame_cnt;
  logic              blink_phase;

  logic              fire;
  logic              is_last;
  logic              swap;

  logic signed [11:0] xs, ys;
  logic              in_win;
  logic [9:0]        dx;
  logic [SW-1:0]     slot_full;
  logic              slot_ok;
  logic [AW-1:0]     rd_addr;
  logic [7:0]        rd_data;

  assign wr_ready = (state != PEND);
  assign busy     = (state == PEND);
  assign fire     = wr_valid & wr_ready & ~clear;
  assign is_last  = wr_last | (wr_ptr == PTR_END);
  assign swap     = (state == PEND) & frame_start & ~clear;

  // Writer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Writer next-state: clear restages from anywhere, otherwise load then wait for a frame.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = PEND;
    end else begin
      case (state)
        IDLE:    if (fire) state_nxt = is_last ? PEND : LOAD;
        LOAD:    if (fire && is_last) state_nxt = PEND;
        PEND:    if (frame_start) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Write pointer and staged/visible lengths.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      shadow_len <= '0;
      active_len <= '0;
    end else begin
      if (clear) begin
        wr_ptr     <= '0;
        shadow_len <= '0;
      end else if (fire) begin
        if (is_last) begin
          shadow_len <= {1'b0, wr_ptr} + LW'(1);
          wr_ptr     <= '0;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
      if (swap) begin
        active_len <= shadow_len;
      end
    end
  end

  // Blink timing: counts frames and flips visibility every half-period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == FC_END) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FCW'(1);
      end
    end
  end

  text_buf_2bank #(
    .N_CHARS(N_CHARS),
    .AW     (AW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (fire),
    .wr_addr(wr_ptr),
    .wr_data(wr_char),
    .swap   (swap),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign xs        = signed'({2'b00, x});
  assign ys        = signed'({2'b00, y});
  assign in_win    = (xs >= X0_S) & (ys >= Y0_S) & (ys < Y1_S);
  assign dx        = x - 10'(TEXT_X0);
  assign slot_full = SW'(dx >> SHIFT);
  assign slot_ok   = in_win & (11'(slot_full) < 11'(active_len));
  assign rd_addr   = AW'(slot_full);

  // Scan path: one-cycle registered glyph request aligned with delayed coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_code <= '0;
      char_x    <= '0;
      char_y    <= '0;
      char_en   <= 1'b0;
    end else begin
      char_code <= slot_ok ? rd_data : 8'd0;
      char_x    <= x;
      char_y    <= y;
      char_en   <= slot_ok & (rd_data != ASCII_SPACE) & ~(blink_en & ~blink_phase);
    end
  end

endmodule
